// File: rtl/slave_axi_pkg.sv
// Shared definitions for the slave-side AXI crossing.
// Purpose : per-channel payload widths and the RD_LAT legality helper.
// Ports   : none (package).
package slave_axi_pkg;

    // Payload widths of the bus-to-slave crossing channels.
    localparam int ADDR_CH_W    = 46;
    localparam int WR_DATA_CH_W = 37;
    localparam int RD_DATA_CH_W = 39;
    localparam int WR_BACK_CH_W = 6;

    // The drain adapter supports FIFO read latencies of 1 or 2 cycles.
    function automatic bit rd_lat_ok(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/slave_axi_drain_ch.sv
// One drain channel: prefetches from a clock-crossing FIFO read port into a
// small circular buffer and presents the words as a valid/ready stream.
// Ports:
//   S_CLK, SLAVE_RSTN_SYNC  clock, async active-low reset
//   fifo_rd_empty           FIFO empty flag
//   fifo_rd_data            FIFO read data, valid RD_LAT cycles after fifo_rd_en
//   fifo_rd_en              FIFO read strobe
//   m_valid/m_data/m_ready  output stream
//   flush                   synchronous discard request
//   idle                    FIFO empty, nothing buffered, nothing in flight
//
// Handshake: a beat transfers on a rising edge where m_valid and m_ready are
// both high. Once m_valid is high, m_valid and m_data hold until that
// transfer (or until flush/reset discards the beat); m_valid never depends
// on m_ready.
module slave_axi_drain_ch
    import slave_axi_pkg::*;
#(
    parameter int DATA_W    = ADDR_CH_W,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2,
    parameter int ZERO_IDLE = 1
) (
    input  logic              S_CLK,
    input  logic              SLAVE_RSTN_SYNC,
    input  logic              fifo_rd_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    input  logic              flush,
    output logic              idle
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LAT + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // occ + infl never exceeds BUF_DEPTH + RD_LAT < 2*(BUF_DEPTH+1).
    localparam int SUM_W = OCC_W + 1;

    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [INF_W-1:0]  infl_q, infl_d;
    logic [RD_LAT-1:0] ret_sr_q, ret_sr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] buf_mem [BUF_DEPTH];

    logic             ret;
    logic             push;
    logic             pop;
    logic             issue;
    logic [SUM_W-1:0] credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Oldest in-flight read returns when it falls out of the shift register.
    assign ret  = ret_sr_q[RD_LAT-1];
    assign push = ret & ~flush;

    assign m_valid = (occ_q != '0) & ~flush;
    assign pop     = m_valid & m_ready;

    // Credit freed by this cycle's pop can be spent by this cycle's read.
    assign credit_used = SUM_W'(occ_q) + SUM_W'(infl_q) - SUM_W'(pop);

    // During flush the FIFO is read whenever non-empty and the data dropped.
    assign fifo_rd_en = SLAVE_RSTN_SYNC & ~fifo_rd_empty &
                        (flush | (credit_used < SUM_W'(BUF_DEPTH)));
    assign issue      = fifo_rd_en & ~flush;

    assign m_data = ((ZERO_IDLE != 0) && !m_valid) ? '0 : buf_mem[rd_ptr_q];
    assign idle   = fifo_rd_empty & (occ_q == '0) & (infl_q == '0);

    always_comb begin
        occ_d    = occ_q;
        infl_d   = infl_q;
        ret_sr_d = ret_sr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            occ_d    = '0;
            infl_d   = '0;
            ret_sr_d = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            // Shift in this cycle's read; the top bit drops out as ret.
            ret_sr_d = RD_LAT'({ret_sr_q, issue});
            occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
            infl_d   = infl_q + INF_W'(issue) - INF_W'(ret);
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge S_CLK or negedge SLAVE_RSTN_SYNC) begin
        if (!SLAVE_RSTN_SYNC) begin
            occ_q    <= '0;
            infl_q   <= '0;
            ret_sr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            occ_q    <= occ_d;
            infl_q   <= infl_d;
            ret_sr_q <= ret_sr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Buffer storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge S_CLK) begin
        if (push) buf_mem[wr_ptr_q] <= fifo_rd_data;
    end

    // Issue credit bounds occ + infl by BUF_DEPTH, so a full buffer can
    // never see a return without a simultaneous pop.
    no_overflow_a: assert property (@(posedge S_CLK) disable iff (!SLAVE_RSTN_SYNC)
        !(push && (occ_q == OCC_W'(BUF_DEPTH)) && !pop))
        else $error("drain channel buffer overflow");

endmodule

// File: rtl/slave_axi_fifo_drain.sv
// Slave-side read adapter: turns NUM_CH clock-crossing FIFO read ports into
// independent valid/ready streams in the S_CLK domain, with per-channel
// flush and idle reporting.
// Ports:
//   S_CLK, SLAVE_RSTN_SYNC  clock, async active-low reset
//   fifo_rd_empty[NUM_CH]   FIFO empty flags
//   fifo_rd_data            channel c at [c*DATA_W +: DATA_W]
//   fifo_rd_en[NUM_CH]      FIFO read strobes
//   m_valid/m_ready[NUM_CH] stream handshake; m_data packed like fifo_rd_data
//   flush[NUM_CH]           synchronous per-channel discard
//   idle[NUM_CH]            channel fully drained
module slave_axi_fifo_drain
    import slave_axi_pkg::*;
#(
    parameter int DATA_W    = ADDR_CH_W,
    parameter int NUM_CH    = 3,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2,
    parameter int ZERO_IDLE = 1
) (
    input  logic                     S_CLK,
    input  logic                     SLAVE_RSTN_SYNC,
    input  logic [NUM_CH-1:0]        fifo_rd_empty,
    input  logic [NUM_CH*DATA_W-1:0] fifo_rd_data,
    output logic [NUM_CH-1:0]        fifo_rd_en,
    output logic [NUM_CH-1:0]        m_valid,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    input  logic [NUM_CH-1:0]        m_ready,
    input  logic [NUM_CH-1:0]        flush,
    output logic [NUM_CH-1:0]        idle
);

    // Full throughput needs one buffer slot per in-flight read plus one.
    localparam bit PARAMS_OK = rd_lat_ok(RD_LAT) && (BUF_DEPTH >= RD_LAT + 1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        slave_axi_drain_ch #(
            .DATA_W    (DATA_W),
            .RD_LAT    (RD_LAT),
            .BUF_DEPTH (BUF_DEPTH),
            .ZERO_IDLE (ZERO_IDLE)
        ) u_ch (
            .S_CLK           (S_CLK),
            .SLAVE_RSTN_SYNC (SLAVE_RSTN_SYNC),
            .fifo_rd_empty   (fifo_rd_empty[c]),
            .fifo_rd_data    (fifo_rd_data[c*DATA_W +: DATA_W]),
            .fifo_rd_en      (fifo_rd_en[c]),
            .m_valid         (m_valid[c]),
            .m_data          (m_data[c*DATA_W +: DATA_W]),
            .m_ready         (m_ready[c]),
            .flush           (flush[c]),
            .idle            (idle[c])
        );
    end

    params_legal_a: assert property (@(posedge S_CLK) PARAMS_OK)
        else $error("slave_axi_fifo_drain: illegal RD_LAT/BUF_DEPTH");

endmodule

// File: doc/slave_axi_fifo_drain.md
# slave_axi_fifo_drain

Parametrised slave-side read adapter that turns the read ports of NUM_CH clock-crossing FIFOs into AXI-style valid/ready streams in the S_CLK domain. It replaces the per-channel single-entry look-ahead registers in the bus-to-slave crossing. Each channel prefetches into a small local buffer, so a FIFO read latency of 1 or 2 cycles still gives one beat per cycle. It adds per-channel flush and per-channel idle reporting.

## Interface
- DATA_W, default 46: payload width per channel, in bits.
- NUM_CH, default 3: number of independent channels.
- RD_LAT, default 1: FIFO read latency in cycles, from rd_en to valid rd_data. Legal values are 1 and 2.
- BUF_DEPTH, default 2: local buffer entries per channel. Must be ≥ RD_LAT+1.
- ZERO_IDLE, default 1: when 1, m_data of a channel is forced to 0 while its m_valid is 0.
- S_CLK  in  1  clock.
- SLAVE_RSTN_SYNC  in  1  reset, asynchronous, active-low.
- fifo_rd_empty  in  NUM_CH  per-channel FIFO empty flag.
- fifo_rd_data  in  NUM_CH*DATA_W  per-channel FIFO read data. Channel c occupies bits [c*DATA_W +: DATA_W].
- fifo_rd_en  out  NUM_CH  per-channel FIFO read strobe.
- m_valid  out  NUM_CH  stream valid.
- m_data  out  NUM_CH*DATA_W  stream payload.
- m_ready  in  NUM_CH  stream ready.
- flush  in  NUM_CH  synchronous per-channel discard request.
- idle  out  NUM_CH  channel fully drained.

## Operation
- Channels are fully independent. Nothing is shared between channels except clock and reset.
- Per-channel state:
  - occ: buffer occupancy, range 0..BUF_DEPTH, width $clog2(BUF_DEPTH+1).
  - infl: reads issued but not yet returned, range 0..RD_LAT.
  - RD_LAT-deep valid shift register marking returning reads.
  - circular buffer with wr_ptr and rd_ptr, each wrapping at BUF_DEPTH-1 → 0.
- Issue rule, normal mode: fifo_rd_en = rstn & ~empty & ~flush & (occ + infl − pop < BUF_DEPTH), where pop = m_valid & m_ready. Credit freed by a pop in this cycle is reused in the same cycle.
- Return: the shift-register output high at a rising edge writes fifo_rd_data at wr_ptr, and wr_ptr increments.
- Output: m_valid = (occ ≠ 0). m_data = buffer[rd_ptr]. A pop increments rd_ptr.
- Push and pop in the same cycle leave occ unchanged.
- An overflow write, meaning a push while occ = BUF_DEPTH with no pop, cannot occur by construction. Add an assertion for it.
- Flush mode, while flush[c] is high:
  - m_valid forced to 0.
  - occ, infl and both pointers cleared on every edge.
  - returning data discarded.
  - fifo_rd_en = ~empty, so the FIFO is drained and its data discarded.
  - When flush falls, normal issuing resumes from the cleared state.
- idle[c] = empty & (occ = 0) & (infl = 0). It is a registered-state function and is valid during flush.
- Reset:
  - fifo_rd_en = 0 and m_valid = 0 while reset is asserted.
  - occ = 0, infl = 0, pointers = 0, buffer contents unspecified.
  - m_data = 0 when ZERO_IDLE = 1.
  - idle follows the empty flag.
- Reset asserted mid-transfer drops all buffered and in-flight beats. No beat is replayed.

## Timing
- First-word latency: empty falls in cycle t, fifo_rd_en is high in cycle t, and m_valid rises in cycle t+RD_LAT+1.
- Sustained throughput is 1 beat per cycle per channel when m_ready is held high and the FIFO stays non-empty. This requires BUF_DEPTH ≥ RD_LAT+1.
- Backpressure: with m_ready low, at most BUF_DEPTH beats are accepted, after which fifo_rd_en stays low. m_data and m_valid stay stable until the pop.
- Flush takes effect on the same cycle for m_valid and fifo_rd_en, which are combinational from flush. State clears at the next edge.
- All outputs are combinational from registered state plus fifo_rd_empty, m_ready and flush. There is no combinational path from fifo_rd_data to any control output.

## Structure
- Shared package slave_axi_pkg holds:
  - channel width constants ADDR_CH_W=46, WR_DATA_CH_W=37, RD_DATA_CH_W=39, WR_BACK_CH_W=6;
  - the legal-RD_LAT check function.
- Sub-module slave_axi_drain_ch implements one channel. The top level is a generate loop over NUM_CH plus parameter assertions.

## Test plan
- Single beat, RD_LAT=1, BUF_DEPTH=2: push 0x2A → fifo_rd_en pulses once, m_valid rises 2 cycles later with m_data=0x2A, idle returns to 1 after the pop.
- Streaming, RD_LAT=2, BUF_DEPTH=3: push 16 beats with m_ready=1 → 16 consecutive valid cycles, data in order 0..15, no bubbles.
- Backpressure: m_ready=0 with 10 beats queued → exactly BUF_DEPTH fifo_rd_en pulses, then m_data is held. Release m_ready → all 10 beats arrive in order.
- Flush mid-burst: flush=1 for 4 cycles with 6 beats queued and 2 buffered → m_valid=0, FIFO drained, idle=1. New beat 0x55 afterwards → delivered alone.
- Channel independence with NUM_CH=3: ch0 stalled, ch1 streaming, ch2 flushed at the same time → ch1 is unaffected and ch0 data is preserved.
- Reset mid-transfer with occ=2 → m_valid=0 and fifo_rd_en=0 immediately, and after reset m_data=0 while idle.
